// File: rtl/gb_pkg.sv
// gb_pkg: shared constants and key-mapping helpers for the Game Boy joypad
// (P1/JOYP) block.
//   - SNES button bit indices within the active-low snes_buttons vector
//   - P1 register bit positions, register address and IF bit index
//   - packed views of the two GB key groups plus SNES -> GB mapping functions
package gb_pkg;

    // SNES controller bit indices (active-low vector from snes_controller)
    localparam int unsigned SNES_B      = 0;
    localparam int unsigned SNES_Y      = 1;
    localparam int unsigned SNES_SELECT = 2;
    localparam int unsigned SNES_START  = 3;
    localparam int unsigned SNES_UP     = 4;
    localparam int unsigned SNES_DOWN   = 5;
    localparam int unsigned SNES_LEFT   = 6;
    localparam int unsigned SNES_RIGHT  = 7;
    localparam int unsigned SNES_A      = 8;
    localparam int unsigned SNES_X      = 9;
    localparam int unsigned SNES_L      = 10;
    localparam int unsigned SNES_R      = 11;

    localparam int unsigned SNES_W      = 12;

    // P1 register layout
    localparam int unsigned P1_SEL_DIR  = 4;
    localparam int unsigned P1_SEL_BTN  = 5;

    localparam logic [15:0] JOYP_ADDR   = 16'hFF00;
    localparam int unsigned IF_JOYPAD   = 4;

    // Direction group as it appears on P13..P10 (active-low)
    typedef struct packed {
        logic down;
        logic up;
        logic left;
        logic right;
    } gb_dir_t;

    // Button group as it appears on P13..P10 (active-low)
    typedef struct packed {
        logic start;
        logic select;
        logic b;
        logic a;
    } gb_btn_t;

    function automatic gb_dir_t map_dir(input logic [SNES_W-1:0] st);
        gb_dir_t d;
        d.down  = st[SNES_DOWN];
        d.up    = st[SNES_UP];
        d.left  = st[SNES_LEFT];
        d.right = st[SNES_RIGHT];
        return d;
    endfunction

    // Active-low: a GB key reads pressed if either SNES source is pressed,
    // which for active-low levels is an AND.
    function automatic gb_btn_t map_btn(input logic [SNES_W-1:0] st);
        gb_btn_t b;
        b.start  = st[SNES_START];
        b.select = st[SNES_SELECT];
        b.b      = st[SNES_B] & st[SNES_Y];
        b.a      = st[SNES_A] & st[SNES_X];
        return b;
    endfunction

endpackage

// File: rtl/gb_debounce.sv
// gb_debounce: vector debounce filter.
//   The input is registered every edge; a counter tracks how long the sample
//   has been unchanged. Once DEBOUNCE_CYCLES consecutive identical samples
//   have been seen, the stable output takes the sampled value.
// Ports:
//   i_clk     clock
//   i_rst     asynchronous reset, active-high (stable/raw -> all released)
//   i_raw     raw active-low input vector
//   o_stable  debounced vector
module gb_debounce #(
    parameter int unsigned WIDTH           = 12,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_raw_q;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_stable;

    // Counter saturates at CNT_LAST; while saturated the stable copy is
    // refreshed every edge, which is harmless since raw_q is unchanged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_raw_q  <= '1;
            r_cnt    <= '0;
            r_stable <= '1;
        end else begin
            r_raw_q <= i_raw;
            if (i_raw != r_raw_q) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_stable <= r_raw_q;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/gb_joypad.sv
// gb_joypad: Game Boy P1/JOYP register (0xFF00) fed by an SNES controller.
//   Debounces snes_buttons, maps the SNES pad onto the GB 2x4 key matrix,
//   holds the CPU-written select bits and raises a one-cycle joypad interrupt
//   on any falling edge of the visible P10..P13 lines.
// Ports:
//   clock         CPU clock
//   rst           asynchronous reset, active-high
//   snes_buttons  active-low SNES buttons (bits 15:12 ignored)
//   cs, wr        CPU access / write strobe for 0xFF00
//   wdata         CPU write data (only bits 5:4 kept)
//   rdata         P1 read value {2'b11, sel, nib}, combinational
//   irq_joypad    one-cycle interrupt request pulse (IF bit 4)
//   any_pressed   registered: any debounced mapped key pressed
module gb_joypad
    import gb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] snes_buttons,
    input  logic        cs,
    input  logic        wr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        irq_joypad,
    output logic        any_pressed
);

    logic [SNES_W-1:0] w_stable;
    gb_dir_t           w_dir;
    gb_btn_t           w_btn;
    logic [3:0]        w_nib;
    logic              w_wr_en;
    logic              w_unused;

    logic [1:0]        r_sel;
    logic [3:0]        r_nib_q;
    logic              r_irq;
    logic              r_any;

    gb_debounce #(
        .WIDTH           (SNES_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .i_clk    (clock),
        .i_rst    (rst),
        .i_raw    (snes_buttons[SNES_W-1:0]),
        .o_stable (w_stable)
    );

    assign w_dir   = map_dir(w_stable);
    assign w_btn   = map_btn(w_stable);
    assign w_wr_en = cs & wr;

    // Select lines are active-low; a deselected group contributes all ones,
    // so selecting both groups ANDs them and selecting neither reads 4'hF.
    always_comb begin
        w_nib = 4'hF;
        if (!r_sel[0]) w_nib = w_nib & w_dir;
        if (!r_sel[1]) w_nib = w_nib & w_btn;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_sel <= 2'b11;
        end else if (w_wr_en) begin
            r_sel <= wdata[P1_SEL_BTN:P1_SEL_DIR];
        end
    end

    // nib_q is the previous cycle's visible nibble; the irq compares it with
    // the current one, so select writes and key presses fire alike.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_nib_q <= 4'hF;
            r_irq   <= 1'b0;
            r_any   <= 1'b0;
        end else begin
            r_nib_q <= w_nib;
            r_irq   <= |(r_nib_q & ~w_nib);
            r_any   <= ~&{w_dir, w_btn};
        end
    end

    assign rdata       = {2'b11, r_sel, w_nib};
    assign irq_joypad  = r_irq;
    assign any_pressed = r_any;

    // Ignored inputs and the unmapped L/R shoulder buttons.
    assign w_unused = &{1'b0, snes_buttons[15:SNES_W], wdata[7:6], wdata[3:0],
                        w_stable[SNES_R], w_stable[SNES_L]};

endmodule
